bin_to_bcd_sequencer: RTL and testbench

- Sequential binary-to-decimal (BCD) converter using shift-and-add-3 (double-dabble), one input bit per clock.
- Replaces the combinational conversion path in the number-conversion exercises with a clocked, handshaked unit.
- Accepts a WIDTH-bit unsigned value on a start pulse and returns DIGITS packed BCD digits with a one-cycle done strobe.
- Intended to sit between a stimulus/testbench driver and a display/$display consumer.

---
 rtl/bin_to_bcd_sequencer.sv | 91 +++++++++
 tb/tb_bin_to_bcd_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_sequencer.sv
// rtl/bin_to_bcd_sequencer.sv - sequential shift-and-add-3 binary to packed BCD converter
module bin_to_bcd_sequencer #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] bin_reg;
    logic [SW-1:0]    scratch;
    logic [CW-1:0]    count;
    logic [SW-1:0]    corrected;
    logic [SW-1:0]    shifted;

    // Every digit is corrected from the pre-edge scratch; 4-bit adds never carry across digits.
    always_comb begin
        corrected = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                corrected[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        shifted = {corrected[SW-2:0], bin_reg[WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            scratch <= '0;
            bin_reg <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_reg <= binary;
                        scratch <= '0;
                        count   <= CW'(WIDTH);
                        state   <= SHIFT;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch <= shifted;
                    bin_reg <= bin_reg << 1;
                    count   <= count - CW'(1);
                    if (count == CW'(1)) begin
                        bcd   <= shifted;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_sequencer.sv
// tb/tb_bin_to_bcd_sequencer.sv - scoreboard bench for bin_to_bcd_sequencer
module tb_bin_to_bcd_sequencer;

    localparam int WIDTH  = 6;
    localparam int DIGITS = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [WIDTH-1:0]     binary;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [4*DIGITS-1:0]  bcd;

    int n_pass  = 0;
    int n_total = 0;
    int n_done  = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    int busy_run = 0;
    logic prev_done = 1'b0;
    logic [4*DIGITS-1:0] sb_q[$];
    int acc_q[$];

    bin_to_bcd_sequencer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .binary (binary),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [4*DIGITS-1:0] b);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (b[4*d +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor samples on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            busy_run = 0;
        end else begin
            check("onehot", 32'($countones({ready, busy, done})), 32'd1);
            if (busy) busy_run++;
            if (done) begin
                n_done++;
                check("done_width", 32'(prev_done), 32'd0);
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) check("bcd", 32'(bcd), 32'(sb_q.pop_front()));
                check("digits_le9", 32'(digits_ok(bcd)), 32'd1);
                check("busy_cycles", 32'(busy_run), 32'(WIDTH));
                // Acceptance is observed on the falling edge just before the accepting edge.
                check("latency", 32'(cyc - acc_cyc), 32'(WIDTH + 1));
                busy_run = 0;
            end
            if (start && ready) begin
                sb_q.push_back(to_bcd(int'(binary)));
                acc_q.push_back(cyc);
                acc_cyc = cyc;
            end
        end
        prev_done = done;
        cyc++;
    end

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < WIDTH + 6; i++) begin
            tick();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(got), 32'd1);
    endtask

    task automatic convert(input int v);
        binary = WIDTH'(v);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done();
        tick();
    endtask

    initial begin
        int nd;
        logic got;
        reset  = 1'b1;
        start  = 1'b0;
        binary = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_bcd",   32'(bcd),   32'd0);

        convert(55);
        check("bcd55", 32'(bcd), 32'h55);
        convert(0);
        convert(9);
        convert(10);
        convert(63);
        check("bcd63_held", 32'(bcd), 32'h63);

        // start held high: only accepted while ready
        acc_q.delete();
        binary = 6'd37;
        start  = 1'b1;
        tick();
        binary = 6'd20;
        got = 1'b0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            if (acc_q.size() >= 2) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        start = 1'b0;
        check("held_accept_timeout", 32'(got), 32'd1);
        if (acc_q.size() >= 2) check("spacing", 32'(acc_q[1] - acc_q[0]), 32'(WIDTH + 2));
        wait_done();
        tick();
        check("bcd20", 32'(bcd), 32'h20);

        // operand change and stray start during SHIFT are ignored
        binary = 6'd55;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        binary = 6'd12;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        check("ignore_bcd", 32'(bcd), 32'h55);
        nd = n_done;
        repeat (WIDTH + 4) tick();
        check("no_extra_done", 32'(n_done - nd), 32'd1);
        check("no_extra_accept", 32'(sb_q.size()), 32'd0);

        // reset sampled at E3 of a conversion of 63
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        binary = 6'd63;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_done",  32'(done),  32'd0);
        check("midrst_bcd",   32'(bcd),   32'h00);
        nd = n_done;
        repeat (WIDTH + 4) tick();
        check("midrst_no_done", 32'(n_done - nd), 32'd0);
        convert(42);
        check("bcd42", 32'(bcd), 32'h42);

        for (int v = 0; v < (1 << WIDTH); v++) convert(v);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
